// File: rtl/ae_pkg.sv
// Shared definitions for the AE add/subtract/transfer unit.
// Sel encodings choose the Y operand fed to the ripple adder.
package ae_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_ADD  = 2'b00;  // Y = B
  localparam sel_t SEL_SUBC = 2'b01;  // Y = ~B
  localparam sel_t SEL_XFER = 2'b10;  // Y = 0
  localparam sel_t SEL_DEC  = 2'b11;  // Y = all ones

endpackage

// File: rtl/ae_full_adder.sv
// Single-bit full adder; one instance per bit of the ripple-carry chain.
module ae_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ae.sv
// Arithmetic element: {Co,D} <= A + Y(Sel,B) + Ci, registered with a
// synchronous active-low reset.
module ae
  import ae_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  input  logic [1:0]       Sel,
  output logic [WIDTH-1:0] D,
  output logic             Co
);

  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] d_q;
  logic             co_q;

  always_comb begin
    y = '0;
    unique case (Sel)
      SEL_ADD:  y = B;
      SEL_SUBC: y = ~B;
      SEL_XFER: y = '0;
      SEL_DEC:  y = '1;
      default:  y = '0;
    endcase
  end

  assign carry[0] = Ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    ae_full_adder u_fa (
      .a    (A[i]),
      .b    (y[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  // Reset wins over any pending result; no asynchronous path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_q  <= '0;
      co_q <= 1'b0;
    end else begin
      d_q  <= sum;
      co_q <= carry[WIDTH];
    end
  end

  assign D  = d_q;
  assign Co = co_q;

endmodule

// File: tb/tb_ae.sv
// Self-checking bench for ae: directed cases, random stream with mid-stream
// reset, and an exhaustive sweep against an arithmetic reference model.
module tb_ae;

  localparam int W = 4;
  localparam int MAXV = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Ci;
  logic [1:0]   Sel;
  logic [W-1:0] D;
  logic         Co;

  int n_checks;
  int n_errors;

  ae #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Ci    (Ci),
    .Sel   (Sel),
    .D     (D),
    .Co    (Co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic of A + Y + Ci, returned as {Co,D}.
  function automatic int model(input int a, input int b, input int c, input int s);
    int y;
    case (s)
      0:       y = b;
      1:       y = MAXV - b;
      2:       y = 0;
      default: y = MAXV;
    endcase
    return a + y + c;
  endfunction

  task automatic apply(input logic r, input int a, input int b, input int c, input int s);
    rst_n = r;
    A     = W'(a);
    B     = W'(b);
    Ci    = c[0];
    Sel   = s[1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input int a, input int b, input int c,
                          input int s, input int exp_d, input int exp_co);
    apply(1'b1, a, b, c, s);
    check({tag, ".D"}, 32'(D), 32'(exp_d));
    check({tag, ".Co"}, 32'(Co), 32'(exp_co));
  endtask

  initial begin
    int prev;
    int cur;
    int a, b, c, s;
    n_checks = 0;
    n_errors = 0;

    // Reset held two edges with non-zero inputs.
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 15, 15, 1, 0);
      check("rst.D", 32'(D), 32'd0);
      check("rst.Co", 32'(Co), 32'd0);
    end

    directed("add_c0",  5, 3, 0, 0, 4'b1000, 0);
    directed("add_c1",  5, 3, 1, 0, 4'b1001, 0);
    directed("subc_c0", 5, 3, 0, 1, 4'b0001, 1);
    directed("subc_c1", 5, 3, 1, 1, 4'b0010, 1);
    directed("xfer_c0", 5, 3, 0, 2, 4'b0101, 0);
    directed("xfer_c1", 5, 3, 1, 2, 4'b0110, 0);
    directed("dec_c0",  5, 3, 0, 3, 4'b0100, 1);
    directed("dec_c1",  5, 3, 1, 3, 4'b0101, 1);
    directed("wrap_add", 15, 1, 0, 0, 4'b0000, 1);
    directed("wrap_dec", 0, 7, 0, 3, 4'b1111, 0);
    directed("borrow",   3, 5, 1, 1, 4'b1110, 0);

    // Random stream: output must hold the previous result until the next edge.
    prev = model(3, 5, 1, 1);
    for (int i = 0; i < 300; i++) begin
      a = int'($urandom_range(MAXV));
      b = int'($urandom_range(MAXV));
      c = int'($urandom_range(1));
      s = int'($urandom_range(3));
      rst_n = (i == 150) ? 1'b0 : 1'b1;
      A = W'(a);
      B = W'(b);
      Ci = c[0];
      Sel = s[1:0];
      #2;
      check("hold", 32'({Co, D}), 32'(prev));
      @(posedge clk);
      #1;
      cur = (i == 150) ? 0 : model(a, b, c, s);
      check(i == 150 ? "midrst" : "stream", 32'({Co, D}), 32'(cur));
      prev = cur;
    end

    // Exhaustive sweep over every operand, carry and select.
    for (int ai = 0; ai <= MAXV; ai++)
      for (int bi = 0; bi <= MAXV; bi++)
        for (int ci = 0; ci < 2; ci++)
          for (int si = 0; si < 4; si++) begin
            apply(1'b1, ai, bi, ci, si);
            check("exh", 32'({Co, D}), 32'(model(ai, bi, ci, si)));
          end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
